ps2_keymatrix: RTL
==================

Name: ps2_keymatrix

Overview:
Upstream feeder of the keyboard matrix input `KM` of the LM80C core. It deserializes raw PS/2 device frames, handles the E0/F0 prefixes, and maps set-2 scancodes to (row, col) positions of the 8x8 LM80C key matrix. It holds a live, active-low matrix image, which the core scans through the PSG port B column select.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized samples needed before `ps2_clk` is accepted as a new level.
TIMEOUT, 16'd50000, `sys_clock` cycles of `ps2_clk` inactivity mid-frame before the frame is aborted (used only with the optional feature).

Ports:
sys_clock  in  1  system clock; the only clock.
RESET  in  1  reset, asynchronous, active-high.
ps2_clk  in  1  raw PS/2 clock from the pad, asynchronous.
ps2_dat  in  1  raw PS/2 data from the pad, asynchronous.
KM  out  8x8 (unpacked [7:0] of [7:0])  key matrix; `KM[row][col]` = 0 means pressed.
scan_strobe  out  1  one-cycle pulse per good frame.
scan_code  out  8  last good byte; valid while `scan_strobe` is high.
frame_err  out  1  sticky error flag (start, parity or stop fault); cleared by the next good frame.

Behaviour:
- Interface: one clock (`sys_clock`); reset is asynchronous and active-high (`RESET`).
- Reset values:
  - `KM` = all 8'hFF.
  - `scan_strobe` = 0, `scan_code` = 0, `frame_err` = 0.
  - FSM in IDLE; `ext`/`brk` flags cleared; skip counter = 0.
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - 2-flop synchronizer on `ps2_clk` and `ps2_dat`.
  - Filtered clock changes level after FILTER_LEN equal samples.
  - A bit is sampled on the filtered falling edge, using the synchronized data.
- FSM, advancing one state per falling edge:
  - IDLE: data = 0 → DATA; data = 1 → stay IDLE (glitch, no error).
  - DATA: 8 bits, LSB first, 3-bit counter → PARITY.
  - PARITY: latch the bit → STOP.
  - STOP: good frame when stop = 1 and odd parity holds over the 8 data bits plus the parity bit.
    - Good frame: `scan_strobe` pulses the next cycle, `scan_code` = byte, `frame_err` = 0.
    - Bad frame: `frame_err` = 1, byte discarded.
  - STOP → IDLE in both cases.
- Byte processing (good frames only, same cycle as `scan_strobe`):
  - Skip counter nonzero: decrement, ignore the byte.
  - E1: set skip counter to 7 (Pause sequence ignored).
  - E0: set `ext`. F0: set `brk`.
  - AA (BAT ok): `KM` forced to all FF; flags cleared.
  - FA, FE, EE, 00, FF: ignored; flags preserved.
  - Any other byte: lookup {ext, code}.
    - Hit: `KM[row][col]` <= brk.
    - Miss: no matrix change.
    - Flags cleared on both hit and miss.
- Latency: `KM` changes 2 cycles after the filtered falling edge that samples the stop bit. A press followed by a release of the same key is last-write-wins.
- Multiple keys may be held simultaneously; no ghosting is modelled.
- Lookup is combinational from a package function; one read per byte, so no pipeline hazards.

Optional Feature:
LM80C_KBD_TIMEOUT_EN:
- Defined: a counter reloads on every filtered `ps2_clk` edge. Reaching TIMEOUT while not in IDLE returns the FSM to IDLE, discards the bits, and sets `frame_err` = 1. Flags are kept.
- Undefined: no watchdog. The FSM waits indefinitely mid-frame, and the TIMEOUT parameter is unused.

Decomposition:
- Package `lm80c_kbd_pkg`:
  - Prefix constants: SC_EXT=8'hE0, SC_BRK=8'hF0, SC_PAUSE=8'hE1, SC_BAT=8'hAA.
  - typedef `key_pos_t` {valid, row[2:0], col[2:0]}.
  - function `keymap(ext, code)` returning `key_pos_t`. Includes 0x1C→(row 2, col 1), 0x12 LShift→(row 6, col 4), E0 0x75 Up→(row 7, col 3).
- Sub-module `ps2_rx`: synchronizer, filter, frame FSM, timeout; outputs byte, strobe and error. The parent holds the prefix logic and the matrix.

Test Plan:
- Reset → `KM` all FF, `frame_err` = 0, no `scan_strobe` while lines idle high.
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) → `scan_strobe` with `scan_code` = 1C; `KM[2]` = 8'hFD exactly 2 cycles after the stop-bit edge.
- Frames F0, 1C after the above → `KM[2]` = FF. Frames E0, 75 → `KM[7]` = F7; E0, F0, 75 → `KM[7]` = FF.
- Frame 0x1C with parity 1 → `frame_err` = 1, `KM` unchanged. Following good 0x12 → `frame_err` = 0, `KM[6]` = EF.
- Hold 0x1C and 0x12, send AA → `KM` all FF. Send E1 then 7 bytes → no change; 8th byte 1C → `KM[2]` = FD.
- Macro defined: stop `ps2_clk` after 4 data bits for TIMEOUT cycles → `frame_err` = 1, FSM in IDLE; next full frame decodes correctly.

Source files
------------

// File: rtl/lm80c_kbd_pkg.sv
// ============================================================================
// Module   : lm80c_kbd_pkg
// Brief    : Shared types, PS/2 prefix codes and set-2 keymap for ps2_keymatrix.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lm80c_kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_BAT   = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    function automatic key_pos_t kp(input logic [2:0] row, input logic [2:0] col);
        return '{valid: 1'b1, row: row, col: col};
    endfunction

    // Device responses that carry no key information and must not touch the flags.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == 8'hFA) || (code == 8'hFE) || (code == 8'hEE) ||
               (code == 8'h00) || (code == 8'hFF);
    endfunction

    function automatic key_pos_t keymap(input logic ext, input logic [7:0] code);
        key_pos_t pos;
        pos = '0;
        if (!ext) begin
            case (code)
                8'h16: pos = kp(3'd0, 3'd1);
                8'h1E: pos = kp(3'd0, 3'd2);
                8'h26: pos = kp(3'd0, 3'd3);
                8'h25: pos = kp(3'd0, 3'd4);
                8'h15: pos = kp(3'd1, 3'd1);
                8'h24: pos = kp(3'd1, 3'd5);
                8'h1D: pos = kp(3'd1, 3'd7);
                8'h1C: pos = kp(3'd2, 3'd1);
                8'h1B: pos = kp(3'd2, 3'd3);
                8'h23: pos = kp(3'd2, 3'd4);
                8'h1A: pos = kp(3'd3, 3'd2);
                8'h22: pos = kp(3'd3, 3'd7);
                8'h5A: pos = kp(3'd5, 3'd1);
                8'h12: pos = kp(3'd6, 3'd4);
                8'h14: pos = kp(3'd7, 3'd2);
                8'h29: pos = kp(3'd7, 3'd4);
                8'h76: pos = kp(3'd7, 3'd7);
                default: pos = '0;
            endcase
        end else begin
            case (code)
                8'h6B: pos = kp(3'd6, 3'd2);
                8'h74: pos = kp(3'd6, 3'd3);
                8'h72: pos = kp(3'd6, 3'd7);
                8'h75: pos = kp(3'd7, 3'd3);
                default: pos = '0;
            endcase
        end
        return pos;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_keymatrix_if.sv
// ============================================================================
// Module   : ps2_keymatrix_if
// Brief    : PS/2 pad lines plus key-matrix / scancode outputs of ps2_keymatrix.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ps2_keymatrix_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] KM [7:0];
    logic       scan_strobe;
    logic [7:0] scan_code;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_dat,
        input  KM, scan_strobe, scan_code, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_dat,
        output KM, scan_strobe, scan_code, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// Module   : ps2_rx
// Brief    : PS/2 frame receiver: synchronizer, clock filter, frame FSM.
//            Optional mid-frame watchdog enabled by LM80C_KBD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx
    import lm80c_kbd_pkg::*;
#(
    parameter int          FILTER_LEN = 8,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       rx_err
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic [CW-1:0] r_fcnt;
    logic          r_level;
    logic          r_level_d;
    rx_state_t     r_state, w_state_n;
    logic [7:0]    r_shift, w_shift_n;
    logic [2:0]    r_bitcnt, w_bitcnt_n;
    logic          r_par, w_par_n;
    logic [7:0]    r_byte, w_byte_n;
    logic          r_strobe, w_strobe_n;
    logic          r_err, w_err_n;
    logic          w_fall;
    logic          w_dat;

    assign w_dat     = r_dat_sync[1];
    assign w_fall    = r_level_d & ~r_level;
    assign rx_byte   = r_byte;
    assign rx_strobe = r_strobe;
    assign rx_err    = r_err;

`ifdef LM80C_KBD_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        w_edge;
    assign w_edge = r_level_d ^ r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_edge) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TIMEOUT) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        w_state_n  = r_state;
        w_shift_n  = r_shift;
        w_bitcnt_n = r_bitcnt;
        w_par_n    = r_par;
        w_byte_n   = r_byte;
        w_strobe_n = 1'b0;
        w_err_n    = r_err;
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_dat) begin
                        w_state_n  = ST_DATA;
                        w_bitcnt_n = 3'd0;
                    end
                end
                ST_DATA: begin
                    w_shift_n  = {w_dat, r_shift[7:1]};
                    w_bitcnt_n = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_n = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    w_par_n   = w_dat;
                    w_state_n = ST_STOP;
                end
                default: begin
                    // Odd parity: data bits plus parity bit must hold an odd count of ones.
                    if (w_dat && (^{r_shift, r_par})) begin
                        w_strobe_n = 1'b1;
                        w_byte_n   = r_shift;
                        w_err_n    = 1'b0;
                    end else begin
                        w_err_n    = 1'b1;
                    end
                    w_state_n = ST_IDLE;
                end
            endcase
        end
`ifdef LM80C_KBD_TIMEOUT_EN
        else if ((r_to_cnt == TIMEOUT) && (r_state != ST_IDLE)) begin
            w_state_n = ST_IDLE;
            w_err_n   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_fcnt     <= '0;
            r_level    <= 1'b1;
            r_level_d  <= 1'b1;
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_par      <= 1'b0;
            r_byte     <= '0;
            r_strobe   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_dat};
            if (r_clk_sync[1] != r_level) begin
                if (r_fcnt == CW'(FILTER_LEN - 1)) begin
                    r_level <= r_clk_sync[1];
                    r_fcnt  <= '0;
                end else begin
                    r_fcnt  <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
            r_level_d <= r_level;
            r_state   <= w_state_n;
            r_shift   <= w_shift_n;
            r_bitcnt  <= w_bitcnt_n;
            r_par     <= w_par_n;
            r_byte    <= w_byte_n;
            r_strobe  <= w_strobe_n;
            r_err     <= w_err_n;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_keymatrix.sv
// ============================================================================
// Module   : ps2_keymatrix
// Brief    : PS/2 set-2 keyboard to LM80C 8x8 active-low key matrix.
//            Optional watchdog: define LM80C_KBD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keymatrix
    import lm80c_kbd_pkg::*;
#(
    parameter int          FILTER_LEN = 8,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic            sys_clock,
    input  logic            RESET,
    ps2_keymatrix_if.slave  kbd
);

    logic [7:0] w_rx_byte;
    logic       w_rx_strobe;
    logic       w_rx_err;
    logic [7:0] r_km [7:0];
    logic       r_ext;
    logic       r_brk;
    logic [2:0] r_skip;
    key_pos_t   w_pos;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk       (sys_clock),
        .rst       (RESET),
        .ps2_clk   (kbd.ps2_clk),
        .ps2_dat   (kbd.ps2_dat),
        .rx_byte   (w_rx_byte),
        .rx_strobe (w_rx_strobe),
        .rx_err    (w_rx_err)
    );

    assign w_pos           = keymap(r_ext, w_rx_byte);
    assign kbd.KM          = r_km;
    assign kbd.scan_strobe = w_rx_strobe;
    assign kbd.scan_code   = w_rx_byte;
    assign kbd.frame_err   = w_rx_err;

    always_ff @(posedge sys_clock or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) begin
                r_km[i] <= 8'hFF;
            end
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= '0;
        end else if (w_rx_strobe) begin
            // Pause (E1) is followed by seven bytes that are swallowed whole.
            if (r_skip != 3'd0) begin
                r_skip <= r_skip - 3'd1;
            end else if (w_rx_byte == SC_PAUSE) begin
                r_skip <= 3'd7;
            end else if (w_rx_byte == SC_EXT) begin
                r_ext <= 1'b1;
            end else if (w_rx_byte == SC_BRK) begin
                r_brk <= 1'b1;
            end else if (w_rx_byte == SC_BAT) begin
                for (int i = 0; i < 8; i++) begin
                    r_km[i] <= 8'hFF;
                end
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (!is_ignored(w_rx_byte)) begin
                if (w_pos.valid) begin
                    r_km[w_pos.row][w_pos.col] <= r_brk;
                end
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
